// File: rtl/cmd_frame_tx.sv
// Command-frame transmitter: header, payload (high word first), optional checksum, trailer,
// serialised MSB-first with a word-sync strobe. Checksum word enabled by CMD_FRAME_CSUM_EN.
module cmd_frame_tx #(
  parameter int                WORD_W  = 16,
  parameter int                N_WORDS = 2,
  parameter logic [WORD_W-1:0] HDR     = 16'h55FF,
  parameter logic [WORD_W-1:0] TRL     = 16'hFFAA,
  parameter int                GAP     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WORD_W*N_WORDS-1:0]    i_in_data,
  input  logic [$clog2(N_WORDS+1)-1:0] i_in_nw,
  input  logic                         i_in_vld,
  output logic                         o_in_rdy,
  output logic                         o_fs,
  output logic                         o_d,
  output logic                         o_busy
);

  localparam int NW_W = $clog2(N_WORDS+1);
  localparam int BW   = $clog2(WORD_W);
  localparam logic [NW_W-1:0] NW_MAX   = NW_W'(N_WORDS);
  localparam logic [BW-1:0]   BIT_LAST = BW'(WORD_W-1);
  localparam logic [7:0]      GAP_LAST = (GAP > 0) ? 8'(GAP-1) : 8'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PAY,
`ifdef CMD_FRAME_CSUM_EN
    S_CSUM,
`endif
    S_TRL, S_GAP
  } state_t;

  state_t                      r_state;
  logic [BW-1:0]               r_bit;
  logic [NW_W-1:0]             r_word;
  logic [NW_W-1:0]             r_nw;
  logic [WORD_W-1:0]           r_sh;
  logic [WORD_W*N_WORDS-1:0]   r_data;
  logic [7:0]                  r_gap;
`ifdef CMD_FRAME_CSUM_EN
  logic [WORD_W-1:0]           r_csum;
`endif

  logic [NW_W-1:0]   w_nw;
  logic              w_last;
  logic [NW_W-1:0]   w_pay_idx;
  logic [WORD_W-1:0] w_pay;
  state_t            w_nxt_state;
  logic [WORD_W-1:0] w_nxt_word;
  logic              w_nxt_fs;

  assign w_nw      = (i_in_nw == '0 || i_in_nw > NW_MAX) ? NW_MAX : i_in_nw;
  assign w_last    = (r_bit == BIT_LAST);
  // Index of the payload word loaded at the end of the current word.
  assign w_pay_idx = (r_state == S_HDR) ? r_nw - 1'b1 : r_word - 1'b1;
  assign w_pay     = r_data[int'(w_pay_idx)*WORD_W +: WORD_W];
  assign w_nxt_fs  = (w_nxt_state != S_IDLE) && (w_nxt_state != S_GAP);

  always_comb begin
    w_nxt_state = S_IDLE;
    w_nxt_word  = '0;
    case (r_state)
      S_HDR: begin
        w_nxt_state = S_PAY;
        w_nxt_word  = w_pay;
      end
      S_PAY: begin
        if (r_word != '0) begin
          w_nxt_state = S_PAY;
          w_nxt_word  = w_pay;
        end else begin
`ifdef CMD_FRAME_CSUM_EN
          w_nxt_state = S_CSUM;
          w_nxt_word  = r_csum;
`else
          w_nxt_state = S_TRL;
          w_nxt_word  = TRL;
`endif
        end
      end
`ifdef CMD_FRAME_CSUM_EN
      S_CSUM: begin
        w_nxt_state = S_TRL;
        w_nxt_word  = TRL;
      end
`endif
      S_TRL:   w_nxt_state = (GAP > 0) ? S_GAP : S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_word  <= '0;
      r_nw    <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_gap   <= '0;
      o_d     <= 1'b0;
      o_fs    <= 1'b0;
`ifdef CMD_FRAME_CSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_vld) begin
            r_state <= S_HDR;
            r_data  <= i_in_data;
            r_nw    <= w_nw;
            r_sh    <= HDR;
            r_bit   <= '0;
            o_d     <= HDR[WORD_W-1];
            o_fs    <= 1'b1;
`ifdef CMD_FRAME_CSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) r_state <= S_IDLE;
          else                   r_gap   <= r_gap + 1'b1;
        end
        default: begin
          if (!w_last) begin
            r_bit <= r_bit + 1'b1;
            r_sh  <= {r_sh[WORD_W-2:0], 1'b0};
            o_d   <= r_sh[WORD_W-2];
            o_fs  <= 1'b0;
          end else begin
            // Word boundary: next word's MSB goes out immediately, no idle bit.
            r_state <= w_nxt_state;
            r_bit   <= '0;
            r_word  <= w_pay_idx;
            r_sh    <= w_nxt_word;
            r_gap   <= '0;
            o_d     <= w_nxt_word[WORD_W-1];
            o_fs    <= w_nxt_fs;
`ifdef CMD_FRAME_CSUM_EN
            if (w_nxt_state == S_PAY) r_csum <= r_csum + w_pay;
`endif
          end
        end
      endcase
    end
  end

  assign o_in_rdy = (r_state == S_IDLE);
  assign o_busy   = ~o_in_rdy;

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Scoreboard bench for cmd_frame_tx: expected words queued at accept, compared as they are
// deserialised from o_fs/o_d.
module tb_cmd_frame_tx;
  localparam int W = 16, NW = 2, GAP = 2;
  localparam logic [15:0] HDRW = 16'h55FF, TRLW = 16'hFFAA;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] i_in_data = '0;
  logic [1:0]  i_in_nw = '0;
  logic        i_in_vld = 1'b0;
  logic        o_in_rdy, o_fs, o_d, o_busy;

  always #5 clk = ~clk;

  cmd_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .i_in_data(i_in_data), .i_in_nw(i_in_nw),
    .i_in_vld(i_in_vld), .o_in_rdy(o_in_rdy), .o_fs(o_fs), .o_d(o_d), .o_busy(o_busy)
  );

  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_q[$];
  int cyc = 0, hdr_cyc = 0, last_trl_cyc = 0, acc_cyc = 0, frm_words = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [31:0] d, input int nw);
    int n;
    logic [15:0] s, w;
    n = (nw == 0 || nw > NW) ? NW : nw;
    s = '0;
    exp_q.push_back(HDRW);
    for (int k = n - 1; k >= 0; k--) begin
      w = d[k*16 +: 16];
      s = s + w;
      exp_q.push_back(w);
    end
`ifdef CMD_FRAME_CSUM_EN
    exp_q.push_back(s);
    frm_words = n + 3;
`else
    frm_words = n + 2;
`endif
    exp_q.push_back(TRLW);
  endtask

  task automatic wait_rdy();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (o_in_rdy) break;
    end
    if (i == 300) chk("rdy_timeout", 0, 1);
  endtask

  task automatic send(input logic [31:0] d, input int nw);
    wait_rdy();
    i_in_data = d; i_in_nw = 2'(nw); i_in_vld = 1'b1;
    @(posedge clk);
    acc_cyc = cyc;
    push_frame(d, nw);
    @(negedge clk);
    i_in_vld = 1'b0; i_in_data = $urandom; i_in_nw = 2'($urandom);
  endtask

  task automatic wait_done(output int rdy_c);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (o_in_rdy && exp_q.size() == 0) break;
    end
    if (i == 2000) chk("done_timeout", 0, 1);
    rdy_c = cyc;
  endtask

  task automatic run_frame(input logic [31:0] d, input int nw);
    int rc;
    send(d, nw);
    wait_done(rc);
    chk("first_bit_lat", hdr_cyc - acc_cyc, 1);
    chk("rdy_return", rc - hdr_cyc, frm_words * W + GAP);
  endtask

  initial begin
    int rc, a_hdr, i;
    fork
      begin : mon
        int cnt, prev_fs;
        logic in_frame;
        logic [15:0] sh, e;
        cnt = 0; prev_fs = 0; in_frame = 1'b0; sh = '0;
        forever begin
          @(negedge clk);
          cyc++;
          if (!rst_n) begin
            cnt = 0; in_frame = 1'b0;
          end else begin
            if (o_busy !== ~o_in_rdy) chk("busy_vs_rdy", o_busy, ~o_in_rdy);
            if (o_fs) begin
              if (cnt != 0) chk("fs_mid_word", cnt, 0);
              if (in_frame) chk("fs_spacing", cyc - prev_fs, W);
              else hdr_cyc = cyc;
              in_frame = 1'b1; prev_fs = cyc; sh = {15'd0, o_d}; cnt = 1;
            end else if (cnt != 0) begin
              sh = {sh[14:0], o_d}; cnt++;
            end else if (o_d) chk("idle_d", o_d, 0);
            if (cnt == W) begin
              cnt = 0;
              if (exp_q.size() == 0) chk("sb_extra_word", sh, 32'hFFFF_FFFF);
              else begin
                e = exp_q.pop_front();
                chk("word", sh, e);
                if (e == TRLW) begin in_frame = 1'b0; last_trl_cyc = cyc; end
              end
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_fs", o_fs, 0); chk("rst_d", o_d, 0); chk("rst_busy", o_busy, 0);
    rst_n = 1'b1; #1;
    chk("rst_rdy", o_in_rdy, 1);

    run_frame(32'h12345678, 2);
    run_frame(32'hFFFF0002, 2);
    run_frame(32'hAAAA5A5A, 1);
    run_frame(32'h12345678, 0);
    run_frame(32'h12345678, 3);

    // Held-valid back-to-back with input churn while busy
    wait_rdy();
    i_in_data = 32'h0F0F1234; i_in_nw = 2'd2; i_in_vld = 1'b1;
    @(posedge clk);
    push_frame(32'h0F0F1234, 2);
    a_hdr = cyc + 1;
    for (i = 0; i < 30; i++) begin
      @(negedge clk); i_in_data = $urandom; i_in_nw = 2'($urandom);
    end
    @(negedge clk);
    i_in_data = 32'h00C3BEEF; i_in_nw = 2'd1;
    push_frame(32'h00C3BEEF, 1);
    for (i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (o_busy) break;
    end
    wait_rdy();
    @(posedge clk);
    @(negedge clk); #1;
    i_in_vld = 1'b0;
    chk("b2b_hdr_seen", hdr_cyc > a_hdr, 1);
    chk("b2b_spacing", hdr_cyc - last_trl_cyc, GAP + 2);
    wait_done(rc);

    // Reset at bit 20 of a frame
    send(32'h7FFF0001, 2);
    for (i = 0; i < 100; i++) begin
      if (cyc >= hdr_cyc + 20 && hdr_cyc > acc_cyc) break;
      @(negedge clk); #1;
    end
    chk("pre_rst_busy", o_busy, 1);
    chk("pre_rst_d", o_d, 1);
    #2 rst_n = 1'b0; #1;
    chk("midrst_d", o_d, 0); chk("midrst_fs", o_fs, 0); chk("midrst_busy", o_busy, 0);
    exp_q.delete();
    @(negedge clk); #1;
    rst_n = 1'b1; #1;
    chk("postrst_rdy", o_in_rdy, 1);
    run_frame(32'h12345678, 2);

    chk("sb_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
